// File: rtl/fb_line_fetch.sv
// fb_line_fetch: doubles a 320x240 RGB565 framebuffer to 640x480 RGB888, fetching one source line ahead into ping-pong buffers.
module fb_line_fetch #(
    parameter logic [31:0] FB_BASE        = 32'h0001_0000,
    parameter int          WORDS_PER_LINE = 160,
    parameter int          SRC_LINES      = 240
) (
    input  logic        clk_pixel,
    input  logic        n_reset,
    input  logic [9:0]  xpos,
    input  logic [9:0]  ypos,
    input  logic        line_end,
    input  logic        frame_end,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [23:0] rgb_data,
    output logic        underrun,
    input  logic        underrun_clr
);
    localparam int              WW         = $clog2(WORDS_PER_LINE);
    localparam logic [WW-1:0]   LAST_W     = WW'(WORDS_PER_LINE - 1);
    localparam logic [9:0]      LAST_Y     = 10'(2 * (SRC_LINES - 1));
    localparam logic [31:0]     LINE_BYTES = 32'(WORDS_PER_LINE * 4);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t        r_state, w_state_nxt;
    logic [WW-1:0] r_w, w_w_nxt;
    logic          r_sel, w_sel_nxt;
    logic [31:0]   r_addr, w_addr_nxt;
    logic          r_underrun, r_fv;
    logic          w_trig, w_last, w_we, w_ur_set;
    logic [9:0]    w_line;
    logic [31:0]   r_buf0 [WORDS_PER_LINE];
    logic [31:0]   r_buf1 [WORDS_PER_LINE];
    logic [31:0]   r_rd;
    logic          r_half, r_act;
    logic [15:0]   w_pix;
    logic [23:0]   w_rgb, r_rgb;

    assign w_trig   = frame_end | (line_end & ~ypos[0] & (ypos < LAST_Y));
    assign w_line   = frame_end ? 10'd0 : {1'b0, ypos[9:1]} + 10'd1;
    assign w_last   = (r_w == LAST_W);
    assign w_we     = n_reset & (r_state == S_REQ) & mem_ack;
    assign w_ur_set = w_trig & (r_state == S_REQ) & ~(mem_ack & w_last);
    assign mem_req  = (r_state == S_REQ);
    assign mem_addr = r_addr;
    assign underrun = r_underrun;
    assign rgb_data = r_rgb;

    // fetch FSM state, word counter, target buffer and request address
    always_ff @(posedge clk_pixel) begin
        if (!n_reset) begin
            r_state <= S_IDLE;
            r_w     <= '0;
            r_sel   <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_w     <= w_w_nxt;
            r_sel   <= w_sel_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    // a trigger always (re)starts a line; otherwise acks walk through the words
    always_comb begin
        w_state_nxt = r_state;
        w_w_nxt     = r_w;
        w_sel_nxt   = r_sel;
        w_addr_nxt  = r_addr;
        if (w_trig) begin
            w_state_nxt = S_REQ;
            w_w_nxt     = '0;
            w_sel_nxt   = w_line[0];
            w_addr_nxt  = FB_BASE + 32'(w_line) * LINE_BYTES;
        end else if (w_we) begin
            w_state_nxt = w_last ? S_IDLE : S_REQ;
            w_w_nxt     = w_last ? r_w : r_w + 1'b1;
            w_addr_nxt  = w_last ? r_addr : r_addr + 32'd4;
        end
    end

    // sticky underrun: set when a line is abandoned unfinished, set beats clear
    always_ff @(posedge clk_pixel) begin
        if (!n_reset) r_underrun <= 1'b0;
        else r_underrun <= (r_underrun & ~underrun_clr) | w_ur_set;
    end

    // output stays black until the first complete frame boundary
    always_ff @(posedge clk_pixel) begin
        if (!n_reset) r_fv <= 1'b0;
        else if (frame_end) r_fv <= 1'b1;
    end

    // line buffer write port; the ack in a restart cycle still lands in the old slot
    always_ff @(posedge clk_pixel) begin
        if (w_we && !r_sel) r_buf0[r_w] <= mem_rdata;
        if (w_we && r_sel) r_buf1[r_w] <= mem_rdata;
    end

    // stage 1: synchronous buffer read plus pixel-half and active flags
    always_ff @(posedge clk_pixel) begin
        r_rd <= ypos[1] ? r_buf1[xpos[9:2]] : r_buf0[xpos[9:2]];
        if (!n_reset) begin
            r_half <= 1'b0;
            r_act  <= 1'b0;
        end else begin
            r_half <= xpos[1];
            r_act  <= r_fv & (xpos < 10'd640) & (ypos < 10'd480);
        end
    end

    assign w_pix = r_half ? r_rd[31:16] : r_rd[15:0];
    assign w_rgb = {w_pix[15:11], w_pix[15:13], w_pix[10:5], w_pix[10:9], w_pix[4:0], w_pix[4:2]};

    // stage 2: registered RGB888, black outside the active area
    always_ff @(posedge clk_pixel) begin
        if (!n_reset) r_rgb <= '0;
        else r_rgb <= r_act ? w_rgb : 24'h0;
    end
endmodule

// File: tb/tb_fb_line_fetch.sv
// tb_fb_line_fetch: scoreboard bench with a behavioural framebuffer/line-buffer model and a randomised memory slave.
module tb_fb_line_fetch;
    localparam int          WPL  = 160;
    localparam int          SRCL = 240;
    localparam logic [31:0] BASE = 32'h0001_0000;

    typedef struct {
        bit          chk;
        logic [23:0] exp;
    } pix_t;

    logic        clk_pixel = 1'b0;
    logic        n_reset = 1'b0;
    logic [9:0]  xpos = '0;
    logic [9:0]  ypos = '0;
    logic        line_end = 1'b0;
    logic        frame_end = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [23:0] rgb_data;
    logic        underrun;
    logic        underrun_clr = 1'b0;

    fb_line_fetch #(
        .FB_BASE(BASE),
        .WORDS_PER_LINE(WPL),
        .SRC_LINES(SRCL)
    ) dut (
        .clk_pixel(clk_pixel),
        .n_reset(n_reset),
        .xpos(xpos),
        .ypos(ypos),
        .line_end(line_end),
        .frame_end(frame_end),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack),
        .rgb_data(rgb_data),
        .underrun(underrun),
        .underrun_clr(underrun_clr)
    );

    always #5 clk_pixel = ~clk_pixel;

    int          n_chk = 0;
    int          n_fail = 0;
    pix_t        pq[$];
    logic [31:0] aq[$];
    logic [31:0] mbuf [2][WPL];
    bit          mk [2][WPL];
    bit          m_fv = 0, n_fv = 0, m_ur = 0, n_ur = 0;
    int          m_line = 0, n_line = 0, m_w = WPL, n_w = WPL;
    bit          pw_en = 0, refill = 0, rst_pend = 0, mon_on = 0;
    int          pw_b, pw_i;
    logic [31:0] pw_d;
    int          mode = 0, stall_at = 0, wcnt = 0;

    function automatic logic [31:0] fb(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [23:0] exp565(input logic [15:0] p);
        int r, g, b;
        r = int'(p) / 2048;
        g = (int'(p) / 32) % 64;
        b = int'(p) % 32;
        r = r * 8 + r / 4;
        g = g * 4 + g / 16;
        b = b * 8 + b / 4;
        return 24'(r * 65536 + g * 256 + b);
    endfunction

    // One clock: commit what happened at the edge just passed, drive new inputs,
    // queue the expected pixel and advance the model for the coming edge.
    task automatic step(input int x, input int y, input bit le, input bit fe, input bit clr, input bit rst);
        pix_t        p;
        bit          ack, trig;
        int          b, wi;
        logic [31:0] wd;
        @(posedge clk_pixel);
        #1;
        if (pw_en) begin
            mbuf[pw_b][pw_i] = pw_d;
            mk[pw_b][pw_i] = 1;
            pw_en = 0;
        end
        if (rst_pend) aq.delete();
        rst_pend = 0;
        if (refill) begin
            aq.delete();
            for (int i = 0; i < WPL; i++) aq.push_back(BASE + 32'((n_line * WPL + i) * 4));
            refill = 0;
        end
        m_fv = n_fv;
        m_ur = n_ur;
        m_line = n_line;
        m_w = n_w;
        xpos = 10'(x);
        ypos = 10'(y);
        line_end = le;
        frame_end = fe;
        underrun_clr = clr;
        n_reset = !rst;
        p.chk = 1;
        p.exp = 24'h0;
        if (rst) begin
            if (pq.size() > 0) begin
                pix_t t;
                t = pq.pop_back();
                t.chk = 1;
                t.exp = 24'h0;
                pq.push_back(t);
            end
        end else if (m_fv && x < 640 && y < 480) begin
            b = (y / 2) % 2;
            wi = x / 4;
            wd = mbuf[b][wi];
            p.chk = mk[b][wi];
            p.exp = ((x / 2) % 2 == 1) ? exp565(wd[31:16]) : exp565(wd[15:0]);
        end
        pq.push_back(p);
        ack = 0;
        mem_rdata = $urandom;
        if (!rst) begin
            if (mode == 1) ack = mem_req;
            else if (mode == 2) begin
                if (mem_req) begin
                    if (wcnt == 0) begin
                        ack = 1;
                        wcnt = $urandom_range(0, 4);
                    end else wcnt--;
                end else ack = ($urandom_range(0, 3) == 0);
            end else if (mode == 3) ack = mem_req && (m_w < stall_at);
        end
        if (ack && mem_req) mem_rdata = fb(mem_addr);
        mem_ack = ack;
        if (rst) begin
            n_fv = 0;
            n_ur = 0;
            n_w = WPL;
            rst_pend = 1;
            refill = 0;
        end else begin
            if (ack && n_w < WPL) begin
                pw_en = 1;
                pw_b = n_line % 2;
                pw_i = n_w;
                pw_d = fb(BASE + 32'((n_line * WPL + n_w) * 4));
                n_w++;
            end
            trig = fe || (le && y % 2 == 0 && y < 2 * (SRCL - 1));
            n_ur = (m_ur && !clr) || (trig && n_w < WPL);
            if (trig) begin
                n_line = fe ? 0 : y / 2 + 1;
                n_w = 0;
                refill = 1;
            end
            if (fe) n_fv = 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step($urandom_range(0, 799), $urandom_range(0, 524), 0, 0, 0, 0);
    endtask

    task automatic wait_fetch();
        int k = 0;
        while (n_w < WPL && k < 3000) begin
            idle(1);
            k++;
        end
        n_chk++;
        if (n_w < WPL) begin
            n_fail++;
            $display("FAIL fetch_timeout: line %0d stuck at word %0d, required %0d words", n_line, n_w, WPL);
        end
        idle(2);
    endtask

    task automatic sweep(input int y);
        for (int x = 0; x < 640; x++) step(x, y, 0, 0, 0, 0);
    endtask

    task automatic do_fe();
        step(639, 479, 0, 1, 0, 0);
    endtask

    task automatic do_le(input int y);
        step(639, y, 1, 0, 0, 0);
    endtask

    pix_t        me;
    logic [31:0] ma;
    // Monitor: pops the scoreboards and checks the bus and flags against the model.
    always @(negedge clk_pixel) begin
        if (pq.size() > 2) begin
            me = pq.pop_front();
            if (me.chk && mon_on) begin
                n_chk++;
                if (rgb_data !== me.exp) begin
                    n_fail++;
                    $display("FAIL rgb_data: got %h, required %h at t=%0t", rgb_data, me.exp, $time);
                end
            end
        end
        if (mon_on) begin
            if (mem_req && mem_ack) begin
                n_chk++;
                if (aq.size() == 0) begin
                    n_fail++;
                    $display("FAIL ack_addr: acked request at %h, required no request", mem_addr);
                end else begin
                    ma = aq.pop_front();
                    if (mem_addr !== ma) begin
                        n_fail++;
                        $display("FAIL ack_addr: got %h, required %h", mem_addr, ma);
                    end
                end
            end
            n_chk++;
            if (mem_req !== (m_w < WPL)) begin
                n_fail++;
                $display("FAIL mem_req: got %b, required %b at t=%0t", mem_req, m_w < WPL, $time);
            end
            if (m_w < WPL) begin
                ma = BASE + 32'((m_line * WPL + m_w) * 4);
                n_chk++;
                if (mem_addr !== ma) begin
                    n_fail++;
                    $display("FAIL mem_addr: got %h, required %h", mem_addr, ma);
                end
            end
            n_chk++;
            if (underrun !== m_ur) begin
                n_fail++;
                $display("FAIL underrun: got %b, required %b at t=%0t", underrun, m_ur, $time);
            end
        end
    end

    initial begin
        step(0, 0, 0, 0, 0, 1);
        mon_on = 1;
        repeat (3) step(0, 0, 0, 0, 0, 1);
        idle(3);
        n_chk++;
        if (mem_addr !== 32'h0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bus: got req=%b addr=%h, required req=0 addr=00000000", mem_req, mem_addr);
        end
        mode = 0;
        do_fe();
        idle(300);
        do_fe();
        idle(20);
        step(700, 10, 0, 0, 1, 0);
        idle(5);
        repeat (3) step(0, 0, 0, 0, 0, 1);
        mode = 1;
        do_fe();
        wait_fetch();
        do_le(0);
        wait_fetch();
        sweep(0);
        sweep(3);
        do_le(1);
        idle(10);
        do_le(2);
        wait_fetch();
        sweep(4);
        do_le(476);
        wait_fetch();
        do_le(478);
        idle(20);
        sweep(477);
        mode = 2;
        do_fe();
        wait_fetch();
        for (int i = 0; i < 6; i++) begin
            int r;
            r = $urandom_range(0, SRCL - 2);
            do_le(2 * r);
            wait_fetch();
            sweep(2 * r + 2);
            idle($urandom_range(5, 40));
        end
        mode = 3;
        stall_at = 10;
        do_le(8);
        idle(40);
        mode = 1;
        do_le(10);
        wait_fetch();
        idle(3);
        step(700, 20, 0, 0, 1, 0);
        idle(3);
        mode = 3;
        do_le(12);
        idle(30);
        mode = 1;
        step(639, 14, 1, 0, 1, 0);
        wait_fetch();
        step(700, 20, 0, 0, 1, 0);
        idle(3);
        do_le(16);
        for (int k = 0; k < 1000 && n_w < 80; k++) idle(1);
        repeat (2) step(100, 2, 0, 0, 0, 1);
        mode = 2;
        idle(30);
        sweep(2);
        mode = 1;
        do_fe();
        wait_fetch();
        sweep(2);
        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
